// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//
// Purpose:
//   Shared types and constants for the multicycle RISC-V core front end.
//   Holds the base-ISA major opcode encoding (opcode_e), the state type of
//   the instruction fetch FSM (fetch_state_e), the canonical NOP word the
//   instruction register resets to, and a helper that classifies an opcode
//   as one the core can execute.
//
// Contents:
//   opcode_e         7-bit major opcode, IR[6:0]
//   fetch_state_e    IDLE / REQ / WAIT for instr_fetch_unit
//   NOP_INSTR        addi x0, x0, 0 (32'h0000_0013)
//   is_legal_opcode  1 when the opcode is one of the nine implemented
//                    major opcodes and its low two bits are 2'b11
// -----------------------------------------------------------------------------
package riscv_pkg;

  // Major opcodes of the RV32I subset implemented by the core.
  typedef enum logic [6:0] {
    OP_L     = 7'b0000011,
    OP_I     = 7'b0010011,
    OP_AUIPC = 7'b0010111,
    OP_S     = 7'b0100011,
    OP_R     = 7'b0110011,
    OP_LUI   = 7'b0110111,
    OP_B     = 7'b1100011,
    OP_JALR  = 7'b1100111,
    OP_JAL   = 7'b1101111
  } opcode_e;

  // Fetch FSM: IDLE waits for a request, REQ holds the bus request until it
  // is granted, WAIT waits for the read data to come back.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- the IR holds this after reset so decode sees a
  // harmless instruction before the first real fetch completes.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Anything whose low two bits are not 2'b11 is a compressed or reserved
  // encoding, which this core does not execute, so it is rejected before the
  // opcode itself is looked at.
  function automatic logic is_legal_opcode(opcode_e op);
    logic [6:0] raw;
    logic       legal;
    raw   = op;
    legal = 1'b0;
    if (raw[1:0] == 2'b11) begin
      case (op)
        OP_L, OP_S, OP_R, OP_B, OP_I,
        OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: legal = 1'b1;
        default:                           legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Multicycle fetch front end. On a request from the main control FSM it
//   reads one 32-bit instruction from instruction memory over a
//   req/gnt/rvalid handshake, writes it into the instruction register (IR)
//   and records the PC it came from (OldPC). IR[6:0] is presented as an
//   opcode_e for the decoder and immediate extender. While a fetch is in
//   flight the IR and OldPC keep the previous instruction, so decode stays
//   stable until fetch_done_o.
//
// Parameters:
//   ADDR_W       instruction address width (default 32)
//   TIMEOUT_CYC  cycles spent in REQ or WAIT before giving up with a bus
//                error (default 16); 0 disables the timeout
//
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   fetch_req_i      start a fetch at pc_i (ignored while busy_o)
//   pc_i             current PC
//   imem_req_o       memory read request, held until imem_gnt_i
//   imem_addr_o      byte address of the word being read ([1:0] = 0)
//   imem_gnt_i       memory accepted the request
//   imem_rvalid_i    read data valid (never in the same cycle as gnt)
//   imem_rdata_i     read data
//   instr_o          IR contents
//   opcode_o         IR[6:0] as opcode_e
//   old_pc_o         PC of the instruction in IR
//   instr_valid_o    IR holds a fetched instruction (cleared only by reset)
//   fetch_done_o     one-cycle pulse: IR was just updated
//   busy_o           fetch in progress (state != IDLE)
//   misalign_o       one-cycle pulse: request had pc_i[1:0] != 0
//   bus_err_o        one-cycle pulse: handshake timed out
//   illegal_instr_o  IR holds an unsupported opcode (optional, see below)
//
// Build options:
//   ILLEGAL_OPCODE_CHECK_EN  when defined, every IR load also registers
//                            whether the loaded opcode is unsupported and
//                            drives it on illegal_instr_o until the next
//                            load. When undefined, illegal_instr_o is 0.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output opcode_e           opcode_o,
  output logic [ADDR_W-1:0] old_pc_o,
  output logic              instr_valid_o,
  output logic              fetch_done_o,
  output logic              busy_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              illegal_instr_o
);

  // The counter must be able to hold TIMEOUT_CYC - 1; keep at least one bit
  // so the design still elaborates with the timeout disabled.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] old_pc_q, old_pc_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic              ir_load;
  logic              timeout_hit;

  // The IR is written exactly when the read data arrives in WAIT; rvalid in
  // any other state is a stale or spurious beat and is dropped.
  assign ir_load = (state_q == WAIT) && imem_rvalid_i;

  // True in the last allowed cycle of REQ/WAIT. Progress (gnt or rvalid) in
  // that same cycle still wins over the timeout.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  // Next-state logic: FSM transitions, address latch, watchdog counter,
  // IR/OldPC update and the single-cycle status pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    old_pc_d   = old_pc_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fetch_req_i) begin
          // A misaligned PC never reaches the memory; it only raises the
          // pulse and leaves the IR untouched.
          if (pc_i[1:0] == 2'b00) begin
            addr_d  = pc_i;
            state_d = REQ;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end

      REQ: begin
        if (imem_gnt_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT: begin
        if (ir_load) begin
          ir_d     = imem_rdata_i;
          old_pc_d = addr_q;
          valid_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (timeout_hit) begin
          state_d   = IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
        end else if (TIMEOUT_CYC != 0) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers. Reset drops any fetch in flight, so a late
  // rvalid after reset lands in IDLE and is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      ir_q       <= NOP_INSTR;
      old_pc_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      old_pc_q   <= old_pc_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

`ifdef ILLEGAL_OPCODE_CHECK_EN
  logic illegal_q, illegal_d;

  // The legality flag tracks the IR: it is re-evaluated on every load and
  // held in between. The IR is loaded regardless of the verdict.
  assign illegal_d = ir_load ? !is_legal_opcode(opcode_e'(imem_rdata_i[6:0]))
                             : illegal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal_instr_o = illegal_q;
`else
  assign illegal_instr_o = 1'b0;
`endif

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = addr_q;
  assign busy_o        = (state_q != IDLE);
  assign instr_o       = ir_q;
  assign opcode_o      = opcode_e'(ir_q[6:0]);
  assign old_pc_o      = old_pc_q;
  assign instr_valid_o = valid_q;
  assign fetch_done_o  = done_q;
  assign misalign_o    = misalign_q;
  assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A table of fetch vectors (aligned and
// misaligned) is replayed with the minimum-latency handshake, followed by
// hand-written sequences for stalls, reset during WAIT, handshake timeouts
// (second instance with TIMEOUT_CYC = 4) and the optional illegal-opcode flag
// (ILLEGAL_OPCODE_CHECK_EN).
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        clock;
  logic        reset;
  logic        fetchReq;
  logic [31:0] pc;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instr;
  opcode_e     opcode;
  logic [31:0] oldPc;
  logic        instrValid;
  logic        fetchDone;
  logic        busy;
  logic        misalign;
  logic        busErr;
  logic        illegal;

  logic        fetchReqTo;
  logic [31:0] pcTo;
  logic        imemReqTo;
  logic [31:0] imemAddrTo;
  logic [31:0] instrTo;
  opcode_e     opcodeTo;
  logic [31:0] oldPcTo;
  logic        instrValidTo;
  logic        fetchDoneTo;
  logic        busyTo;
  logic        misalignTo;
  logic        busErrTo;
  logic        illegalTo;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk_i          (clock),
    .rst_i          (reset),
    .fetch_req_i    (fetchReq),
    .pc_i           (pc),
    .imem_req_o     (imemReq),
    .imem_addr_o    (imemAddr),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .instr_o        (instr),
    .opcode_o       (opcode),
    .old_pc_o       (oldPc),
    .instr_valid_o  (instrValid),
    .fetch_done_o   (fetchDone),
    .busy_o         (busy),
    .misalign_o     (misalign),
    .bus_err_o      (busErr),
    .illegal_instr_o(illegal)
  );

  instr_fetch_unit #(.ADDR_W(32), .TIMEOUT_CYC(4)) dutTo (
    .clk_i          (clock),
    .rst_i          (reset),
    .fetch_req_i    (fetchReqTo),
    .pc_i           (pcTo),
    .imem_req_o     (imemReqTo),
    .imem_addr_o    (imemAddrTo),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .instr_o        (instrTo),
    .opcode_o       (opcodeTo),
    .old_pc_o       (oldPcTo),
    .instr_valid_o  (instrValidTo),
    .fetch_done_o   (fetchDoneTo),
    .busy_o         (busyTo),
    .misalign_o     (misalignTo),
    .bus_err_o      (busErrTo),
    .illegal_instr_o(illegalTo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always ends even if something goes badly wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        expMis;
    logic [31:0] expInstr;
    logic [6:0]  expOp;
    logic [31:0] expOldPc;
  } vec_t;

  vec_t vecs[6];

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // inputs changed there too, well away from the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Replay one table entry with gnt in cycle 1 and rvalid in cycle 2.
  task automatic applyStimulus(input vec_t v, input logic [31:0] prevInstr,
                               input logic [31:0] prevOldPc);
    fetchReq = 1'b1;
    pc       = v.pc;
    tick();
    fetchReq = 1'b0;
    if (v.expMis) begin
      checkOutput("mis_pulse", {31'b0, misalign}, 32'd1);
      checkOutput("mis_req", {31'b0, imemReq}, 32'd0);
      checkOutput("mis_busy", {31'b0, busy}, 32'd0);
      checkOutput("mis_instr", instr, v.expInstr);
      checkOutput("mis_oldpc", oldPc, v.expOldPc);
      tick();
      checkOutput("mis_pulse_end", {31'b0, misalign}, 32'd0);
      checkOutput("mis_req_after", {31'b0, imemReq}, 32'd0);
    end else begin
      checkOutput("req_high", {31'b0, imemReq}, 32'd1);
      checkOutput("req_addr", imemAddr, v.pc);
      checkOutput("busy_req", {31'b0, busy}, 32'd1);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      checkOutput("wait_req_low", {31'b0, imemReq}, 32'd0);
      checkOutput("wait_ir_hold", instr, prevInstr);
      checkOutput("wait_oldpc_hold", oldPc, prevOldPc);
      rvalid = 1'b1;
      rdata  = v.rdata;
      tick();
      rvalid = 1'b0;
      rdata  = 32'h0;
      checkOutput("done_pulse", {31'b0, fetchDone}, 32'd1);
      checkOutput("ir", instr, v.expInstr);
      checkOutput("opcode", {25'b0, opcode}, {25'b0, v.expOp});
      checkOutput("oldpc", oldPc, v.expOldPc);
      checkOutput("valid", {31'b0, instrValid}, 32'd1);
      checkOutput("busy_done", {31'b0, busy}, 32'd0);
      tick();
      checkOutput("done_end", {31'b0, fetchDone}, 32'd0);
    end
  endtask

  // Minimum-latency fetch on the main instance without intermediate checks.
  task automatic doFetch(input logic [31:0] fpc, input logic [31:0] fdata);
    fetchReq = 1'b1;
    pc       = fpc;
    tick();
    fetchReq = 1'b0;
    gnt      = 1'b1;
    tick();
    gnt      = 1'b0;
    rvalid   = 1'b1;
    rdata    = fdata;
    tick();
    rvalid   = 1'b0;
    rdata    = 32'h0;
  endtask

  initial begin
    logic [31:0] curInstr;
    logic [31:0] curOldPc;
    logic        expIll;

    vecs[0] = '{32'h0000_0100, 32'h0050_0093, 1'b0, 32'h0050_0093, 7'h13, 32'h0000_0100};
    vecs[1] = '{32'h0000_0204, 32'h0000_A283, 1'b0, 32'h0000_A283, 7'h03, 32'h0000_0204};
    vecs[2] = '{32'h0000_0102, 32'hDEAD_BEEF, 1'b1, 32'h0000_A283, 7'h03, 32'h0000_0204};
    vecs[3] = '{32'h0000_1000, 32'h00B5_0533, 1'b0, 32'h00B5_0533, 7'h33, 32'h0000_1000};
    vecs[4] = '{32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, 32'hFE00_0EE3, 7'h63, 32'hFFFF_FFFC};
    vecs[5] = '{32'h0000_0003, 32'h1111_1111, 1'b1, 32'hFE00_0EE3, 7'h63, 32'hFFFF_FFFC};

    reset      = 1'b1;
    fetchReq   = 1'b0;
    pc         = 32'h0;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    rdata      = 32'h0;
    fetchReqTo = 1'b0;
    pcTo       = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_opcode", {25'b0, opcode}, 32'h13);
    checkOutput("rst_oldpc", oldPc, 32'h0);
    checkOutput("rst_valid", {31'b0, instrValid}, 32'd0);
    checkOutput("rst_req", {31'b0, imemReq}, 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, fetchDone}, 32'd0);
    checkOutput("rst_mis", {31'b0, misalign}, 32'd0);
    checkOutput("rst_buserr", {31'b0, busErr}, 32'd0);
    checkOutput("rst_illegal", {31'b0, illegal}, 32'd0);

    // Table of basic and misaligned fetches.
    curInstr = 32'h0000_0013;
    curOldPc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], curInstr, curOldPc);
      checkOutput("tbl_illegal", {31'b0, illegal}, 32'd0);
      curInstr = vecs[i].expInstr;
      curOldPc = vecs[i].expOldPc;
    end

    // Stall: gnt three cycles late, rvalid four cycles after gnt, and a
    // stray fetch request in both REQ and WAIT that must be ignored.
    fetchReq = 1'b1;
    pc       = 32'h0000_0300;
    tick();
    fetchReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_req", {31'b0, imemReq}, 32'd1);
      checkOutput("stall_addr", imemAddr, 32'h0000_0300);
      if (i == 1) begin
        fetchReq = 1'b1;
        pc       = 32'h0000_0500;
      end
      tick();
      fetchReq = 1'b0;
    end
    checkOutput("stall_addr_pre_gnt", imemAddr, 32'h0000_0300);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_wait_req", {31'b0, imemReq}, 32'd0);
      checkOutput("stall_ir_hold", instr, 32'hFE00_0EE3);
      checkOutput("stall_done_low", {31'b0, fetchDone}, 32'd0);
      checkOutput("stall_busy", {31'b0, busy}, 32'd1);
      if (i == 0) begin
        fetchReq = 1'b1;
        pc       = 32'h0000_0600;
      end
      tick();
      fetchReq = 1'b0;
    end
    rvalid = 1'b1;
    rdata  = 32'h1234_5037;
    tick();
    rvalid = 1'b0;
    checkOutput("stall_ir", instr, 32'h1234_5037);
    checkOutput("stall_opcode", {25'b0, opcode}, 32'h37);
    checkOutput("stall_oldpc", oldPc, 32'h0000_0300);
    checkOutput("stall_done", {31'b0, fetchDone}, 32'd1);
    tick();
    checkOutput("stall_no_queue_busy", {31'b0, busy}, 32'd0);
    checkOutput("stall_no_queue_req", {31'b0, imemReq}, 32'd0);
    checkOutput("stall_addr_kept", imemAddr, 32'h0000_0300);

    // Reset while waiting for read data, then a late rvalid.
    fetchReq = 1'b1;
    pc       = 32'h0000_0700;
    tick();
    fetchReq = 1'b0;
    gnt      = 1'b1;
    tick();
    gnt   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstw_busy", {31'b0, busy}, 32'd0);
    rvalid = 1'b1;
    rdata  = 32'hFFFF_FFFF;
    tick();
    rvalid = 1'b0;
    checkOutput("rstw_instr", instr, 32'h0000_0013);
    checkOutput("rstw_valid", {31'b0, instrValid}, 32'd0);
    checkOutput("rstw_done", {31'b0, fetchDone}, 32'd0);
    tick();
    checkOutput("rstw_done2", {31'b0, fetchDone}, 32'd0);
    checkOutput("rstw_instr2", instr, 32'h0000_0013);

    // Timeout in REQ on the TIMEOUT_CYC = 4 instance: gnt never comes.
    fetchReqTo = 1'b1;
    pcTo       = 32'h0000_0040;
    tick();
    fetchReqTo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_req_busy", {31'b0, busyTo}, 32'd1);
      checkOutput("to_req_req", {31'b0, imemReqTo}, 32'd1);
      checkOutput("to_req_err_low", {31'b0, busErrTo}, 32'd0);
      tick();
    end
    checkOutput("to_req_err", {31'b0, busErrTo}, 32'd1);
    checkOutput("to_req_idle", {31'b0, busyTo}, 32'd0);
    checkOutput("to_req_reqlow", {31'b0, imemReqTo}, 32'd0);
    checkOutput("to_req_instr", instrTo, 32'h0000_0013);
    checkOutput("to_req_valid", {31'b0, instrValidTo}, 32'd0);
    tick();
    checkOutput("to_req_err_end", {31'b0, busErrTo}, 32'd0);

    // Timeout in WAIT: granted, but rvalid never arrives.
    fetchReqTo = 1'b1;
    pcTo       = 32'h0000_0080;
    tick();
    fetchReqTo = 1'b0;
    gnt        = 1'b1;
    tick();
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_wait_busy", {31'b0, busyTo}, 32'd1);
      checkOutput("to_wait_err_low", {31'b0, busErrTo}, 32'd0);
      tick();
    end
    checkOutput("to_wait_err", {31'b0, busErrTo}, 32'd1);
    checkOutput("to_wait_idle", {31'b0, busyTo}, 32'd0);
    checkOutput("to_wait_instr", instrTo, 32'h0000_0013);
    checkOutput("to_wait_done", {31'b0, fetchDoneTo}, 32'd0);
    tick();
    checkOutput("to_wait_err_end", {31'b0, busErrTo}, 32'd0);

    // Illegal-opcode flag: set by 0x7F, cleared by a following NOP.
`ifdef ILLEGAL_OPCODE_CHECK_EN
    expIll = 1'b1;
`else
    expIll = 1'b0;
`endif
    doFetch(32'h0000_0800, 32'h0000_007F);
    checkOutput("ill_instr", instr, 32'h0000_007F);
    checkOutput("ill_flag", {31'b0, illegal}, {31'b0, expIll});
    tick();
    checkOutput("ill_hold", {31'b0, illegal}, {31'b0, expIll});
    doFetch(32'h0000_0804, 32'h0000_0013);
    checkOutput("ill_clear_instr", instr, 32'h0000_0013);
    checkOutput("ill_clear", {31'b0, illegal}, 32'd0);
    checkOutput("ill_oldpc", oldPc, 32'h0000_0804);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
